// File: rtl/mux16_arb_defs.sv
// Shared constants and state encoding for the 16-way round-robin mux arbiter.
package mux16_arb_defs;

  localparam int unsigned NREQ   = 16;
  localparam int unsigned SWIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: rotate req by ptr, fixed-priority encode, un-rotate.
module rr_pick16
  import mux16_arb_defs::*;
(
  input  logic [NREQ-1:0]   req,
  input  logic [SWIDTH-1:0] ptr,
  output logic              any,
  output logic [SWIDTH-1:0] w
);

  logic [NREQ-1:0]   rot;
  logic [SWIDTH-1:0] idx;

  // rot[i] is requester (ptr+i) mod 16; lowest set bit of rot wins
  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rot[i] = req[SWIDTH'(i) + ptr];
    end
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) idx = SWIDTH'(i);
    end
    any = |req;
    w   = idx + ptr;
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 mux among 16 requesters, with a valid/ready
// output channel and a one-cycle ack back to the accepted requester.
module mux16_rr_arbiter
  import mux16_arb_defs::*;
#(
  parameter int unsigned width  = 4,
  parameter int unsigned swidth = SWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*width-1:0]  din,
  output logic [NREQ-1:0]        ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic [swidth-1:0]      out_sel
);

  state_e              state_q, state_d;
  logic [swidth-1:0]   ptr_q, ptr_d;
  logic [swidth-1:0]   sel_q, sel_d;
  logic [width-1:0]    data_q, data_d;

  logic                pick_any;
  logic [swidth-1:0]   pick_w;
  logic [width-1:0]    pick_data;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .w   (pick_w)
  );

  // 16:1 data mux driven by the picker's winner
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_w == swidth'(i)) pick_data = din[i*width +: width];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_w;
          data_d  = pick_data;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          ptr_d   = sel_q + swidth'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  // Ack decodes from registered state, so it stays low while reset holds the FSM idle
  always_comb begin
    ack = '0;
    if ((state_q == ST_HOLD) && out_ready) ack[sel_q] = 1'b1;
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mux16_rr_arbiter;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   req;
  logic [16*W-1:0] din;
  logic [15:0]   ack;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_sel;

  int checks = 0;
  int failures = 0;

  mux16_rr_arbiter #(.width(W), .swidth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Round-robin winner from the rule: first k in ptr, ptr+1, ... (mod 16) with req[k]
  function automatic int rr_winner(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) din[i*W +: W] = 4'(15 - i);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_sel !== 4'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    checks++; if (ack !== 16'h0) begin failures++; $display("FAIL reset_ack got=%h exp=0", ack); end
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd0 || out_data !== 4'hF) begin
      failures++; $display("FAIL reset_first_grant got v=%b sel=%0d d=%h exp v=1 sel=0 d=f", out_valid, out_sel, out_data); end
    checks++; if (ack !== 16'h0001) begin failures++; $display("FAIL reset_first_ack got=%h exp=0001", ack); end
    req = 16'h0;
    tick();
    checks++; if (out_valid !== 1'b0 || ack !== 16'h0) begin
      failures++; $display("FAIL reset_after_ack got v=%b ack=%h exp v=0 ack=0", out_valid, ack); end
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0020; din = '0; din[5*W +: W] = 4'hC; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pre got v=%b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hC || out_sel !== 4'd5) begin
      failures++; $display("FAIL single_grant got v=%b d=%h sel=%0d exp v=1 d=c sel=5", out_valid, out_data, out_sel); end
    checks++; if (ack !== 16'h0020) begin failures++; $display("FAIL single_ack got=%h exp=0020", ack); end
    req = 16'h0;
    tick();
    checks++; if (out_valid !== 1'b0 || ack !== 16'h0 || out_sel !== 4'd5) begin
      failures++; $display("FAIL single_done got v=%b ack=%h sel=%0d exp v=0 ack=0 sel=5", out_valid, ack, out_sel); end
    // ptr is now 6: requester 6 beats requester 0
    req = 16'h0041; din[6*W +: W] = 4'h6; din[0 +: W] = 4'h9;
    tick();
    checks++; if (out_sel !== 4'd6 || out_data !== 4'h6) begin
      failures++; $display("FAIL single_ptr6 got sel=%0d d=%h exp sel=6 d=6", out_sel, out_data); end
    req = 16'h0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) din[i*W +: W] = 4'(i);
    for (int g = 0; g < 17; g++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_sel !== 4'(g % 16) || out_data !== 4'(g % 16)) begin
        failures++; $display("FAIL rr_grant%0d got v=%b sel=%0d d=%h exp v=1 sel=%0d", g, out_valid, out_sel, out_data, g % 16); end
      checks++; if (ack !== (16'h1 << (g % 16))) begin
        failures++; $display("FAIL rr_ack%0d got=%h exp=%h", g, ack, 16'h1 << (g % 16)); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_idle%0d got v=%b exp 0", g, out_valid); end
    end
    req = 16'h0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 16'h0008; din = '0; din[3*W +: W] = 4'hA; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd3 || out_data !== 4'hA) begin
      failures++; $display("FAIL bp_grant got v=%b sel=%0d d=%h exp v=1 sel=3 d=a", out_valid, out_sel, out_data); end
    din[3*W +: W] = 4'h1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 4'd3 || ack !== 16'h0) begin
        failures++; $display("FAIL bp_hold%0d got v=%b d=%h sel=%0d ack=%h exp v=1 d=a sel=3 ack=0", c, out_valid, out_data, out_sel, ack); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (ack !== 16'h0008) begin failures++; $display("FAIL bp_ack got=%h exp=0008", ack); end
    req = 16'h0;
    tick();
    checks++; if (ack !== 16'h0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_ack_once got ack=%h v=%b exp ack=0 v=0", ack, out_valid); end
  endtask

  task automatic test_wrap_skip();
    int exp_order [3];
    exp_order = '{0, 1, 13};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) din[i*W +: W] = 4'(i ^ 5);
    req = 16'h2000;
    tick();
    req = 16'h0;
    tick();
    req = 16'h2003;
    for (int g = 0; g < 3; g++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_sel !== 4'(exp_order[g]) || out_data !== 4'(exp_order[g] ^ 5)) begin
        failures++; $display("FAIL wrap_grant%0d got v=%b sel=%0d d=%h exp sel=%0d", g, out_valid, out_sel, out_data, exp_order[g]); end
      req[exp_order[g]] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    out_ready = 1'b0; req = 16'h0080;
    for (int i = 0; i < 16; i++) din[i*W +: W] = 4'(i);
    tick();
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd7) begin
      failures++; $display("FAIL rsth_grant got v=%b sel=%0d exp v=1 sel=7", out_valid, out_sel); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || ack !== 16'h0) begin
      failures++; $display("FAIL rsth_drop got v=%b ack=%h exp v=0 ack=0", out_valid, ack); end
    rst = 1'b0; req = 16'h0081; out_ready = 1'b1;
    tick();
    checks++; if (out_sel !== 4'd0 || ack !== 16'h0001) begin
      failures++; $display("FAIL rsth_regrant got sel=%0d ack=%h exp sel=0 ack=0001", out_sel, ack); end
    req = 16'h0;
    tick();
  endtask

  task automatic test_random();
    bit       m_busy = 0;
    int       m_ptr = 0;
    int       m_sel = 0;
    logic [W-1:0] m_data = '0;
    int       acked;
    int       wn;
    logic [15:0] exp_ack;
    do_reset();
    req = 16'h0; din = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 16; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          din[i*W +: W] = 4'($urandom);
        end
      end
      #1;
      exp_ack = (m_busy && out_ready) ? (16'h1 << m_sel) : 16'h0;
      checks++; if (ack !== exp_ack) begin
        failures++; $display("FAIL rand_ack c%0d got=%h exp=%h", cyc, ack, exp_ack); end
      acked = -1;
      if (!m_busy) begin
        wn = rr_winner(req, m_ptr);
        if (wn >= 0) begin
          m_busy = 1; m_sel = wn; m_data = din[wn*W +: W];
        end
      end else if (out_ready) begin
        acked = m_sel;
        m_ptr = (m_sel + 1) % 16;
        m_busy = 0;
      end
      tick();
      if (acked >= 0) req[acked] = 1'b0;
      checks++; if (out_valid !== m_busy || out_sel !== 4'(m_sel) || (m_busy && out_data !== m_data)) begin
        failures++; $display("FAIL rand_out c%0d got v=%b sel=%0d d=%h exp v=%b sel=%0d d=%h",
                             cyc, out_valid, out_sel, out_data, m_busy, m_sel, m_data); end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
